// File: rtl/dec_entry_round.sv
// dec_entry_round: decimal-entry round with LFSR target and double-dabble BCD.
// Define DIGIT_HINT_EN to build the per-digit hint comparators.
module dec_entry_round #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_VALUE = 9999
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_new_round,
    input  logic        i_next,
    input  logic        i_check,
    input  logic [9:0]  i_switches,
    input  logic        i_target_ld,
    input  logic [13:0] i_target_in,
    output logic [13:0] o_target,
    output logic        o_target_valid,
    output logic [3:0]  o_d3,
    output logic [3:0]  o_d2,
    output logic [3:0]  o_d1,
    output logic [3:0]  o_d0,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_correct,
    output logic [3:0]  o_hint
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GEN     = 3'd1,
        S_CONV    = 3'd2,
        S_ENTER   = 3'd3,
        S_COMPARE = 3'd4,
        S_RESULT  = 3'd5
    } state_t;

    localparam logic [13:0] MAXV = 14'(MAX_VALUE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic        r_nr_q;
    logic        r_next_q;
    logic        r_chk_q;
    logic [13:0] r_target;
    logic [29:0] r_dd;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;
    logic [3:0]  r_d3;
    logic [3:0]  r_d2;
    logic [3:0]  r_d1;
    logic [3:0]  r_d0;
    logic        r_correct;

    logic        w_nr_ev;
    logic        w_next_ev;
    logic        w_chk_ev;
    logic        w_gen_hit;
    logic        w_conv_last;
    logic        w_load_conv;
    logic        w_clr_digits;
    logic        w_shift;
    logic        w_onehot;
    logic [3:0]  w_digit;
    logic [13:0] w_ld_val;
    logic [13:0] w_conv_src;
    logic [29:0] w_dd_adj;
    logic [29:0] w_dd_step;

    assign w_nr_ev     = i_new_round & ~r_nr_q;
    assign w_next_ev   = i_next & ~r_next_q;
    assign w_chk_ev    = i_check & ~r_chk_q;
    assign w_gen_hit   = (r_lfsr[13:0] <= MAXV);
    assign w_conv_last = (r_cnt == 4'd13);
    assign w_ld_val    = (i_target_in > MAXV) ? MAXV : i_target_in;
    assign w_conv_src  = (r_state == S_GEN) ? r_lfsr[13:0] : w_ld_val;
    assign w_onehot    = $onehot(i_switches);
    assign w_load_conv = (w_state_nxt == S_CONV) && (r_state != S_CONV);
    assign w_clr_digits = ((r_state == S_CONV) && w_conv_last) ||
                          ((r_state == S_ENTER) && w_nr_ev);
    assign w_shift     = (r_state == S_ENTER) && w_next_ev &&
                         !w_chk_ev && !w_nr_ev && w_onehot;

    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (i_switches[k]) w_digit = 4'(k);
        end
    end

    // Double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        w_dd_adj = r_dd;
        for (int k = 0; k < 4; k++) begin
            if (r_dd[14+4*k +: 4] >= 4'd5)
                w_dd_adj[14+4*k +: 4] = r_dd[14+4*k +: 4] + 4'd3;
        end
        w_dd_step = w_dd_adj << 1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_target_ld)  w_state_nxt = S_CONV;
                else if (w_nr_ev) w_state_nxt = S_GEN;
            end
            S_GEN:     if (w_gen_hit) w_state_nxt = S_CONV;
            S_CONV:    if (w_conv_last) w_state_nxt = S_ENTER;
            S_ENTER: begin
                if (w_nr_ev)       w_state_nxt = S_GEN;
                else if (w_chk_ev) w_state_nxt = S_COMPARE;
            end
            S_COMPARE: w_state_nxt = S_RESULT;
            S_RESULT: begin
                if (i_target_ld)  w_state_nxt = S_CONV;
                else if (w_nr_ev) w_state_nxt = S_GEN;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (r_state == S_GEN) || (r_state == S_CONV);
        o_done         = (r_state == S_RESULT);
        o_target_valid = (r_state == S_ENTER) || (r_state == S_COMPARE) ||
                         (r_state == S_RESULT);
        o_hint         = 4'b0000;
`ifdef DIGIT_HINT_EN
        if (r_state == S_ENTER)
            o_hint = {r_d3 == r_bcd[15:12], r_d2 == r_bcd[11:8],
                      r_d1 == r_bcd[7:4],   r_d0 == r_bcd[3:0]};
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr    <= SEED;
            r_nr_q    <= 1'b0;
            r_next_q  <= 1'b0;
            r_chk_q   <= 1'b0;
            r_target  <= '0;
            r_dd      <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_d3      <= '0;
            r_d2      <= '0;
            r_d1      <= '0;
            r_d0      <= '0;
            r_correct <= 1'b0;
        end else begin
            // Free-running so the player's timing seeds the target.
            r_lfsr   <= {r_lfsr[14:0],
                         r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_nr_q   <= i_new_round;
            r_next_q <= i_next;
            r_chk_q  <= i_check;
            if (w_load_conv) begin
                r_target <= w_conv_src;
                r_dd     <= {16'd0, w_conv_src};
                r_cnt    <= '0;
            end else if (r_state == S_CONV) begin
                r_dd  <= w_dd_step;
                r_cnt <= r_cnt + 4'd1;
                if (w_conv_last) r_bcd <= w_dd_step[29:14];
            end
            if (w_clr_digits) begin
                r_d3 <= '0;
                r_d2 <= '0;
                r_d1 <= '0;
                r_d0 <= '0;
            end else if (w_shift) begin
                r_d3 <= r_d2;
                r_d2 <= r_d1;
                r_d1 <= r_d0;
                r_d0 <= w_digit;
            end
            if (r_state == S_COMPARE)
                r_correct <= ({r_d3, r_d2, r_d1, r_d0} == r_bcd);
            else if ((r_state == S_RESULT) && (w_state_nxt != S_RESULT))
                r_correct <= 1'b0;
        end
    end

    assign o_target  = r_target;
    assign o_d3      = r_d3;
    assign o_d2      = r_d2;
    assign o_d1      = r_d1;
    assign o_d0      = r_d0;
    assign o_correct = r_correct;

endmodule

// File: tb/tb_dec_entry_round.sv
// tb_dec_entry_round: directed plus randomized rounds against a decimal model.
// Expected hints follow DIGIT_HINT_EN when the bench is built with it.
module tb_dec_entry_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nr  = 1'b0;
    logic        nx  = 1'b0;
    logic        ck  = 1'b0;
    logic        tld = 1'b0;
    logic [9:0]  sw  = '0;
    logic [13:0] tin = '0;

    logic [13:0] o_target;
    logic        o_tv;
    logic [3:0]  o_d3, o_d2, o_d1, o_d0;
    logic        o_busy, o_done, o_correct;
    logic [3:0]  o_hint;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    int          m_ent = 0;
    int          m_tgt = 0;

    always #5 clk = ~clk;

    dec_entry_round dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_new_round    (nr),
        .i_next         (nx),
        .i_check        (ck),
        .i_switches     (sw),
        .i_target_ld    (tld),
        .i_target_in    (tin),
        .o_target       (o_target),
        .o_target_valid (o_tv),
        .o_d3           (o_d3),
        .o_d2           (o_d2),
        .o_d1           (o_d1),
        .o_d0           (o_d0),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_correct      (o_correct),
        .o_hint         (o_hint)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, one step per clock out of reset.
    always @(posedge clk) begin
        if (rst) m_lfsr = 16'hACE1;
        else     m_lfsr = {m_lfsr[14:0],
                           m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] dec4(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10),   4'(v % 10)};
    endfunction

    function automatic logic [3:0] hint_exp();
        logic [3:0]  h;
        logic [15:0] a;
        logic [15:0] b;
        h = 4'b0000;
        a = dec4(m_ent);
        b = dec4(m_tgt);
`ifdef DIGIT_HINT_EN
        for (int i = 0; i < 4; i++) h[i] = (a[4*i +: 4] == b[4*i +: 4]);
`endif
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_target"}, 32'(o_target), 0);
        chk({tag, "_tvalid"}, 32'(o_tv), 0);
        chk({tag, "_digits"}, 32'({o_d3, o_d2, o_d1, o_d0}), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_correct"}, 32'(o_correct), 0);
        chk({tag, "_hint"}, 32'(o_hint), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nr = 0; nx = 0; ck = 0; tld = 0; sw = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        m_ent = 0;
        m_tgt = 0;
    endtask

    task automatic conv_wait(input int exp_t);
        int n;
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            tick();
        end
        chk("conv_cycles", n, 14);
        chk("target", 32'(o_target), exp_t);
        chk("tvalid", 32'(o_tv), 1);
        chk("digits_clear", 32'({o_d3, o_d2, o_d1, o_d0}), 0);
        m_ent = 0;
        m_tgt = exp_t;
    endtask

    task automatic load(input int t);
        tin = 14'(t);
        tld = 1'b1;
        tick();
        tld = 1'b0;
        conv_wait((t > 9999) ? 9999 : t);
    endtask

    task automatic round_lfsr(input bit abort);
        int k;
        int pred;
        k = 0;
        nr = 1'b1;
        tick();
        nr = 1'b0;
        chk("gen_busy", 32'(o_busy), 1);
        chk("gen_done", 32'(o_done), 0);
        chk("gen_correct", 32'(o_correct), 0);
        if (abort) chk("abort_digits", 32'({o_d3, o_d2, o_d1, o_d0}), 0);
        // First LFSR value in range seen while generating becomes the target.
        while (m_lfsr[13:0] > 14'd9999 && k < 2000) begin
            k++;
            tick();
        end
        pred = int'(m_lfsr[13:0]);
        tick();
        conv_wait(pred);
    endtask

    task automatic digit(input int d);
        sw = 10'd1 << d;
        nx = 1'b1;
        tick();
        nx = 1'b0;
        tick();
        m_ent = (m_ent * 10 + d) % 10000;
        chk("digits", 32'({o_d3, o_d2, o_d1, o_d0}), 32'(dec4(m_ent)));
        chk("hint", 32'(o_hint), 32'(hint_exp()));
    endtask

    task automatic bad_press(input logic [9:0] v);
        sw = v;
        nx = 1'b1;
        tick();
        nx = 1'b0;
        tick();
        chk("bad_press", 32'({o_d3, o_d2, o_d1, o_d0}), 32'(dec4(m_ent)));
    endtask

    task automatic submit();
        ck = 1'b1;
        tick();
        ck = 1'b0;
        tick();
        chk("done", 32'(o_done), 1);
        chk("correct", 32'(o_correct), 32'(m_ent == m_tgt));
        chk("hint_result", 32'(o_hint), 0);
    endtask

    initial begin
        int a;
        int b;
        int nd;

        do_reset();

        load(1234);
        digit(1); digit(2); digit(3); digit(4);
        submit();
        chk("t1_correct", 32'(o_correct), 1);

        load(16383);
        digit(9); digit(9); digit(9); digit(8);
        submit();
        chk("t2_correct", 32'(o_correct), 0);
        round_lfsr(1'b0);
        submit();

        load(0);
        digit(5);
        bad_press(10'b0000000011);
        bad_press(10'b0000000000);
        digit(0); digit(0); digit(0); digit(0);
        submit();
        chk("t3_correct", 32'(o_correct), 1);

        load(56);
        digit(0); digit(0); digit(5); digit(7);
`ifdef DIGIT_HINT_EN
        chk("hint_0057", 32'(o_hint), 32'(4'b1110));
`endif
        digit(7); digit(0); digit(0); digit(5); digit(6);
        chk("five_digits", 32'({o_d3, o_d2, o_d1, o_d0}), 32'(16'h0056));
        submit();
        chk("t4_correct", 32'(o_correct), 1);

        load(3);
        sw = 10'b0000001000;
        nx = 1'b1;
        repeat (1000) tick();
        nx = 1'b0;
        tick();
        m_ent = 3;
        chk("hold_next", 32'({o_d3, o_d2, o_d1, o_d0}), 32'(16'h0003));
        sw = 10'b0010000000;
        nx = 1'b1;
        ck = 1'b1;
        tick();
        nx = 1'b0;
        ck = 1'b0;
        tick();
        chk("next_check_done", 32'(o_done), 1);
        chk("next_check_digits", 32'({o_d3, o_d2, o_d1, o_d0}), 32'(16'h0003));
        chk("next_check_correct", 32'(o_correct), 1);

        round_lfsr(1'b0);
        digit(4);
        round_lfsr(1'b1);
        submit();

        do_reset();
        round_lfsr(1'b0);
        chk("seed_range", 32'(o_target <= 14'd9999), 1);
        submit();

        do_reset();
        tin = 14'd777;
        tld = 1'b1;
        tick();
        tld = 1'b0;
        repeat (5) tick();
        chk("midconv_busy", 32'(o_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midconv_reset");
        tick();
        chk("midconv_idle", 32'(o_busy), 0);
        m_ent = 0;
        m_tgt = 0;

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, 16383)));
            else round_lfsr(1'b0);
            if ($urandom_range(0, 2) == 0) begin
                digit(m_tgt / 1000 % 10);
                digit(m_tgt / 100 % 10);
                digit(m_tgt / 10 % 10);
                digit(m_tgt % 10);
            end else begin
                nd = int'($urandom_range(0, 6));
                for (int i = 0; i < nd; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        a = int'($urandom_range(0, 9));
                        b = (a + 1 + int'($urandom_range(0, 8))) % 10;
                        bad_press((10'd1 << a) | (10'd1 << b));
                    end else begin
                        digit(int'($urandom_range(0, 9)));
                    end
                end
            end
            submit();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
